// File: rtl/spdif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spdif_pkg
// Brief    : Shared constants and types for the biphase-mark subframe encoder.
// Revision : 1.0 - initial release
// ============================================================================
package spdif_pkg;

    localparam int SUBFRAME_SLOTS      = 32;
    localparam int HALF_CELLS          = 64;
    localparam int FRAMES_PER_BLOCK    = 192;
    localparam int PREAMBLE_HALF_CELLS = 8;

    localparam int SLOT_DATA = 4;
    localparam int SLOT_V    = 28;
    localparam int SLOT_U    = 29;
    localparam int SLOT_C    = 30;
    localparam int SLOT_P    = 31;

    // First half-cell is the MSB
    localparam logic [7:0] PREAMBLE_B = 8'b1110_1000;
    localparam logic [7:0] PREAMBLE_M = 8'b1110_0010;
    localparam logic [7:0] PREAMBLE_W = 8'b1110_0100;

    typedef enum logic [1:0] {
        IDLE_RESET = 2'd0,
        PREAMBLE   = 2'd1,
        DATA       = 2'd2
    } bmc_state_t;

    typedef struct packed {
        logic [23:0] sample;
        logic        valid_bit;
        logic        user_bit;
    } sample_t;

endpackage
`default_nettype wire

// File: rtl/biphasemark_encode_if.sv
`default_nettype none
// ============================================================================
// Module   : biphasemark_encode_if
// Brief    : Sample handshake, channel-status and line-side signals of the encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface biphasemark_encode_if;

    logic [23:0]  din;
    logic         din_channel;
    logic         din_valid_bit;
    logic         din_user_bit;
    logic         vin;
    logic         ready;
    logic [191:0] cs_block;
    logic         dout;
    logic [7:0]   frame_counter;
    logic         channel;
    logic         underrun;

    modport master (
        output din, din_channel, din_valid_bit, din_user_bit, vin, cs_block,
        input  ready, dout, frame_counter, channel, underrun
    );

    modport slave (
        input  din, din_channel, din_valid_bit, din_user_bit, vin, cs_block,
        output ready, dout, frame_counter, channel, underrun
    );

endinterface
`default_nettype wire

// File: rtl/bmc_subframe_builder.sv
`default_nettype none
// ============================================================================
// Module   : bmc_subframe_builder
// Brief    : Assembles the 32-slot subframe word (audio, V/U/C, even parity).
// Revision : 1.0 - initial release
// ============================================================================
module bmc_subframe_builder
    import spdif_pkg::*;
(
    input  sample_t                   i_buf,
    input  logic                      i_use_buf,
    input  logic                      i_cs_bit,
    output logic [SUBFRAME_SLOTS-1:0] o_word
);

    logic [SUBFRAME_SLOTS-1:0] w_word;

    always_comb begin
        w_word = '0;
        if (i_use_buf) begin
            w_word[SLOT_V-1:SLOT_DATA] = i_buf.sample;
            w_word[SLOT_V]             = i_buf.valid_bit;
            w_word[SLOT_U]             = i_buf.user_bit;
        end else begin
            // Substituted silence is flagged as not valid audio
            w_word[SLOT_V] = 1'b1;
        end
        w_word[SLOT_C] = i_cs_bit;
        w_word[SLOT_P] = ^w_word[SLOT_C:SLOT_DATA];
    end

    assign o_word = w_word;

endmodule
`default_nettype wire

// File: rtl/biphasemark_encode.sv
`default_nettype none
// ============================================================================
// Module   : biphasemark_encode
// Brief    : AES3/S/PDIF biphase-mark line encoder with one-sample holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
module biphasemark_encode
    import spdif_pkg::*;
#(
    parameter int HALF_CELL_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    biphasemark_encode_if.slave  bus
);

    localparam int c_DIV_W = (HALF_CELL_DIV > 1) ? $clog2(HALF_CELL_DIV) : 1;

    logic [c_DIV_W-1:0]        r_div;
    logic [5:0]                r_hc;
    bmc_state_t                r_state;
    bmc_state_t                w_state_next;
    logic                      r_dout;
    logic                      r_channel;
    logic [7:0]                r_frame;
    logic                      r_underrun;
    logic [7:0]                r_pre;
    logic [SUBFRAME_SLOTS-1:0] r_word;
    logic [191:0]              r_cs;
    logic                      r_buf_full;
    logic                      r_buf_chan;
    sample_t                   r_buf;

    logic                      w_strobe;
    logic                      w_hc0;
    logic                      w_match;
    logic                      w_accept;
    logic                      w_cs_bit;
    logic                      w_slot_bit;
    logic                      w_level;
    logic [7:0]                w_pre_base;
    logic [SUBFRAME_SLOTS-1:0] w_word;

    assign w_strobe   = (r_div == c_DIV_W'(HALF_CELL_DIV - 1));
    assign w_hc0      = w_strobe && (r_hc == '0);
    assign w_match    = r_buf_full && (r_buf_chan == r_channel);
    assign w_accept   = bus.vin && !r_buf_full;
    assign w_slot_bit = r_word[r_hc[5:1]];

    // Frame 0 channel A latches cs_block on this very strobe, so read it live
    assign w_cs_bit = (r_frame == '0 && !r_channel) ? bus.cs_block[0] : r_cs[r_frame];

    always_comb begin
        if (r_channel)
            w_pre_base = PREAMBLE_W;
        else if (r_frame == '0)
            w_pre_base = PREAMBLE_B;
        else
            w_pre_base = PREAMBLE_M;
    end

    bmc_subframe_builder u_builder (
        .i_buf     (r_buf),
        .i_use_buf (w_match),
        .i_cs_bit  (w_cs_bit),
        .o_word    (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_div <= '0;
        else if (w_strobe)
            r_div <= '0;
        else
            r_div <= r_div + c_DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE_RESET;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_level      = r_dout;
        if (w_strobe) begin
            if (r_hc < 6'(PREAMBLE_HALF_CELLS)) begin
                w_state_next = PREAMBLE;
                w_level      = (r_hc == '0) ? (w_pre_base[7] ^ r_dout)
                                            : r_pre[3'd7 - r_hc[2:0]];
            end else begin
                w_state_next = DATA;
                w_level      = r_hc[0] ? (r_dout ^ w_slot_bit) : ~r_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout     <= 1'b0;
            r_hc       <= '0;
            r_channel  <= 1'b0;
            r_frame    <= '0;
            r_underrun <= 1'b0;
            r_pre      <= '0;
            r_word     <= '0;
            r_cs       <= '0;
        end else begin
            r_underrun <= 1'b0;
            if (w_strobe) begin
                r_dout <= w_level;
                r_hc   <= r_hc + 6'd1;
                if (r_hc == 6'(HALF_CELLS - 1)) begin
                    r_channel <= ~r_channel;
                    if (r_channel)
                        r_frame <= (r_frame == 8'(FRAMES_PER_BLOCK - 1)) ? '0 : r_frame + 8'd1;
                end
            end
            if (w_hc0) begin
                r_word     <= w_word;
                r_pre      <= w_pre_base ^ {8{r_dout}};
                r_underrun <= !w_match;
                if (!r_channel && r_frame == '0)
                    r_cs <= bus.cs_block;
            end
        end
    end

    // A mismatched sample stays put until its own channel comes round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_full <= 1'b0;
            r_buf_chan <= 1'b0;
            r_buf      <= '0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
            r_buf_chan <= bus.din_channel;
            r_buf      <= {bus.din, bus.din_valid_bit, bus.din_user_bit};
        end else if (w_hc0 && w_match) begin
            r_buf_full <= 1'b0;
        end
    end

    assign bus.ready         = !r_buf_full;
    assign bus.dout          = r_dout;
    assign bus.frame_counter = r_frame;
    assign bus.channel       = r_channel;
    assign bus.underrun      = r_underrun;

endmodule
`default_nettype wire

// File: doc/biphasemark_encode.md
BIPHASEMARK_ENCODE -- requirements
Module: biphasemark_encode

Interface
REQ-001 Parameter HALF_CELL_DIV, default 1: clk cycles per BMC half-cell (1 at 6.144 MHz gives a 48 kHz frame rate).
REQ-002 clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  24  audio sample, LSB transmitted first.
REQ-005 din_channel  input  1  sample's channel tag (0=A, 1=B).
REQ-006 din_valid_bit  input  1  V bit for the sample.
REQ-007 din_user_bit  input  1  U bit for the sample.
REQ-008 vin  input  1  sample offered.
REQ-009 ready  output  1  holding buffer empty; a sample transfers when vin && ready.
REQ-010 cs_block  input  192  channel-status block, latched at each block start.
REQ-011 dout  output  1  BMC line level.
REQ-012 frame_counter  output  8  current frame index, 0..191.
REQ-013 channel  output  1  channel of the subframe being transmitted.
REQ-014 underrun  output  1  one-cycle pulse per subframe sent without a matching sample.

Function
REQ-015 A divider SHALL strobe once every HALF_CELL_DIV cycles; dout SHALL change only on strobe.
REQ-016 Subframe timing: 64 half-cells; slot k occupies half-cells 2k and 2k+1.
REQ-017 Slots 0-3 carry the preamble; slots 4-27 carry din[0..23]; slots 28/29/30 carry V/U/C; slot 31 carries P.
REQ-018 P SHALL equal the XOR of slots 4..30, giving even parity over slots 4..31.
REQ-019 C SHALL equal the latched cs_block[frame_counter], identical in the A and B subframes.
REQ-020 Preamble selection (base pattern, first half-cell first):
  - B = 11101000 when channel A and frame_counter==0.
  - M = 11100010 for other channel-A subframes.
  - W = 11100100 for channel B.
  - The pattern SHALL be inverted when the last emitted half-cell was 1.
REQ-021 Data cell encoding:
  - first half = NOT(previous half-cell level);
  - second half = first half XOR bit.
REQ-022 Subframe load: at the half-cell-0 strobe, the block SHALL load the subframe from the holding buffer when the buffer is full and its tag equals the due channel.
  - The buffer then empties and ready rises the next cycle.
  - A same-cycle vin && ready SHALL NOT be lost.
REQ-023 Underrun: when the buffer is empty or its tag mismatches, the subframe SHALL send sample 0 with V=1 and U=0, and pulse underrun.
  - A mismatched sample SHALL be retained for the next subframe.
REQ-024 Channel SHALL toggle every subframe; frame_counter SHALL increment after each B subframe and wrap 191 to 0.
  - cs_block SHALL be latched at the wrap.
REQ-025 Latency: a sample accepted during subframe n SHALL be transmitted in the first subframe of its channel starting after acceptance.

Reset
REQ-026 While rst_n is low, the outputs SHALL be:
  - dout=0, ready=1, frame_counter=0, channel=0, underrun=0;
  - buffer empty, previous level 0, divider 0, cs_block latch 0.
REQ-027 Reset assertion mid-subframe SHALL take effect immediately and discard any partial subframe.
REQ-028 On release, the first strobe SHALL start a channel-A subframe with preamble B, latching cs_block at that point.

Structure
REQ-029 Package spdif_pkg SHALL hold:
  - preamble constants B/M/W;
  - SUBFRAME_SLOTS=32, HALF_CELLS=64, FRAMES_PER_BLOCK=192;
  - slot index constants for V/U/C/P.
REQ-030 Sub-module bmc_subframe_builder SHALL assemble the 32-slot word and parity from the buffer; the top SHALL own the timing, FSM and serializer.
REQ-031 The FSM SHALL have states IDLE_RESET, PREAMBLE, DATA, with PREAMBLE entered at each half-cell 0.

Verification
REQ-032 Reset with vin=0: dout half-cells 0-7 = 11101000; subframe carries V=1, sample 0; underrun pulses; ready=1.
REQ-033 A-tagged sample din=24'h000001 with V=U=0 and cs_block=0, with HALF_CELL_DIV=1: expected response:
  - the next A subframe emits half-cells 8-9 = 1,0;
  - slot 31 P=1.
REQ-034 Alternating A/B samples for 192 frames with cs_block[5]=1: expected response:
  - frame 5 has C=1 in both subframes and C=0 elsewhere;
  - frame_counter wraps 191 to 0;
  - the next A subframe uses preamble B.
REQ-035 Offer a B-tagged sample when A is due: the A subframe underruns; the sample is sent in the following subframe with preamble W; ready stays 0 until then.
REQ-036 HALF_CELL_DIV=4: each half-cell holds for 4 cycles; a subframe spans 256 cycles; the encoding is unchanged.
REQ-037 Drop rst_n at half-cell 30: dout=0 immediately; after release, preamble B restarts at frame_counter=0.
